// File: rtl/glyph_pkg.sv
// ============================================================================
// Module   : glyph_pkg
// Purpose  : Shared constants and types for the sprite/glyph pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package glyph_pkg;

  localparam int RGB_W = 24;
  localparam int GLYPH_W = 32;
  localparam int GLYPH_H = 32;
  localparam logic [RGB_W-1:0] KEY_RGB = 24'hFF00FF;

  // Glyph indices within the ROM
  localparam int GLYPH_KART = 0;
  localparam int GLYPH_OBSTACLE = 1;

  typedef logic [RGB_W-1:0] rgb_t;

endpackage

`default_nettype wire

// File: rtl/glyph_hit_calc.sv
// ============================================================================
// Module   : glyph_hit_calc
// Purpose  : Combinational sprite hit test and glyph ROM address generation
//            for one sprite layer. The optional mirror is applied through
//            the flip input (tied low when mirroring is not built in).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module glyph_hit_calc
  import glyph_pkg::*;
#(
  parameter int COORD_W    = 10,
  parameter int ADDR_WIDTH = 12,
  parameter int SEL_W      = 2,
  parameter int GLYPH_W    = glyph_pkg::GLYPH_W,
  parameter int GLYPH_H    = glyph_pkg::GLYPH_H
) (
  input  logic                  en,
  input  logic                  pix_valid,
  input  logic                  flip,
  input  logic [COORD_W-1:0]    pix_x,
  input  logic [COORD_W-1:0]    pix_y,
  input  logic [COORD_W-1:0]    sx,
  input  logic [COORD_W-1:0]    sy,
  input  logic [SEL_W-1:0]      sel,
  output logic                  hit,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int LW     = $clog2(GLYPH_W);
  localparam int LH     = $clog2(GLYPH_H);
  localparam int FULL_W = SEL_W + LH + LW;
  localparam logic [COORD_W:0] C_GW = (COORD_W+1)'(GLYPH_W);
  localparam logic [COORD_W:0] C_GH = (COORD_W+1)'(GLYPH_H);

  logic [COORD_W:0] w_dx;
  logic [COORD_W:0] w_dy;
  logic [LW-1:0]    w_col;
  logic [FULL_W-1:0] w_full;

  // Extended-width offsets so a sprite near the coordinate limit never wraps
  assign w_dx = {1'b0, pix_x} - {1'b0, sx};
  assign w_dy = {1'b0, pix_y} - {1'b0, sy};

  assign hit = en & pix_valid &
               ({1'b0, pix_x} >= {1'b0, sx}) & ({1'b0, pix_y} >= {1'b0, sy}) &
               (w_dx < C_GW) & (w_dy < C_GH);

  // GLYPH_W is a power of two, so GLYPH_W-1-dx equals the bitwise inverse
  assign w_col  = flip ? ~w_dx[LW-1:0] : w_dx[LW-1:0];
  assign w_full = {sel, w_dy[LH-1:0], w_col};

  generate
    if (ADDR_WIDTH == FULL_W) begin : g_addr_exact
      assign addr = w_full;
    end else if (ADDR_WIDTH > FULL_W) begin : g_addr_zext
      assign addr = {{(ADDR_WIDTH-FULL_W){1'b0}}, w_full};
    end else begin : g_addr_trunc
      assign addr = w_full[ADDR_WIDTH-1:0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/glyph_renderer.sv
// ============================================================================
// Module   : glyph_renderer
// Purpose  : Sprite pixel pipeline: frame-shadowed sprite registers, glyph
//            ROM addressing, colour-key compositing, 3-cycle fixed latency.
//            Optional macro GLYPH_MIRROR_EN adds spr_flip (horizontal mirror).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module glyph_renderer
  import glyph_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 12,
  parameter int COORD_W    = 10,
  parameter int GLYPH_W    = glyph_pkg::GLYPH_W,
  parameter int GLYPH_H    = glyph_pkg::GLYPH_H,
  parameter int SEL_W      = 2,
  parameter logic [DATA_WIDTH-1:0] KEY_RGB = glyph_pkg::KEY_RGB
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [COORD_W-1:0]    pix_x,
  input  logic [COORD_W-1:0]    pix_y,
  input  logic [DATA_WIDTH-1:0] bg_rgb,
  input  logic [COORD_W-1:0]    spr_x,
  input  logic [COORD_W-1:0]    spr_y,
  input  logic [SEL_W-1:0]      spr_sel,
  input  logic                  spr_en,
`ifdef GLYPH_MIRROR_EN
  input  logic                  spr_flip,
`endif
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] out_rgb,
  output logic                  out_valid,
  output logic                  out_hit
);

  logic [COORD_W-1:0]    r_sx;
  logic [COORD_W-1:0]    r_sy;
  logic [SEL_W-1:0]      r_sel;
  logic                  r_en;
  logic                  w_flip;

  logic                  w_hit0;
  logic [ADDR_WIDTH-1:0] w_addr0;

  logic                  r_v1;
  logic                  r_hit1;
  logic [DATA_WIDTH-1:0] r_bg1;
  logic                  r_v2;
  logic                  r_hit2;
  logic [DATA_WIDTH-1:0] r_bg2;
  logic                  w_opaque;

`ifdef GLYPH_MIRROR_EN
  logic r_flip;

  // Mirror control is shadowed alongside the other sprite registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_flip <= 1'b0;
    else if (frame_start) r_flip <= spr_flip;
  end

  assign w_flip = r_flip;
`else
  assign w_flip = 1'b0;
`endif

  // Capture sprite registers only at frame start so mid-frame writes cannot tear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sx  <= '0;
      r_sy  <= '0;
      r_sel <= '0;
      r_en  <= 1'b0;
    end else if (frame_start) begin
      r_sx  <= spr_x;
      r_sy  <= spr_y;
      r_sel <= spr_sel;
      r_en  <= spr_en;
    end
  end

  glyph_hit_calc #(
    .COORD_W    (COORD_W),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEL_W      (SEL_W),
    .GLYPH_W    (GLYPH_W),
    .GLYPH_H    (GLYPH_H)
  ) u_hit_calc (
    .en        (r_en),
    .pix_valid (pix_valid),
    .flip      (w_flip),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .sx        (r_sx),
    .sy        (r_sy),
    .sel       (r_sel),
    .hit       (w_hit0),
    .addr      (w_addr0)
  );

  // Colour-key transparency on the ROM word aligned with stage 2
  assign w_opaque = r_hit2 & (rom_q != KEY_RGB);

  // Three-stage pixel pipeline; the ROM address only moves on a sprite hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      r_v1      <= 1'b0;
      r_hit1    <= 1'b0;
      r_bg1     <= '0;
      r_v2      <= 1'b0;
      r_hit2    <= 1'b0;
      r_bg2     <= '0;
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_rgb   <= '0;
    end else begin
      if (w_hit0) rom_addr <= w_addr0;
      r_v1      <= pix_valid;
      r_hit1    <= w_hit0;
      r_bg1     <= bg_rgb;
      r_v2      <= r_v1;
      r_hit2    <= r_hit1;
      r_bg2     <= r_bg1;
      out_valid <= r_v2;
      out_hit   <= w_opaque;
      out_rgb   <= w_opaque ? rom_q : (r_v2 ? r_bg2 : '0);
    end
  end

endmodule

`default_nettype wire

// File: doc/glyph_renderer.md
Name: glyph_renderer

Overview:
- Sprite pixel pipeline between the VGA timing generator and the glyph ROM.
- Latches per-frame sprite position and glyph select, then generates the ROM address for each incoming pixel coordinate.
- Consumes the ROM's registered colour word, applies colour-key transparency, and outputs a composited RGB pixel aligned with a 3-cycle-delayed valid.
- Glyphs are GLYPH_W x GLYPH_H, row-major, each one based at glyph_sel*GLYPH_W*GLYPH_H (glyph 0 at 0, glyph 1 at 1024).

Parameters:
DATA_WIDTH, 24, RGB word width (matches ROM q)
ADDR_WIDTH, 12, ROM address width
COORD_W, 10, pixel coordinate width
GLYPH_W, 32, glyph width in pixels (power of two)
GLYPH_H, 32, glyph height in pixels (power of two)
SEL_W, 2, glyph select width
KEY_RGB, 24'hFF00FF, transparent colour key

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
pix_valid  in  1  pix_x/pix_y/bg_rgb valid this cycle
pix_x  in  COORD_W  current pixel column
pix_y  in  COORD_W  current pixel row
bg_rgb  in  DATA_WIDTH  background colour for this pixel
spr_x  in  COORD_W  sprite top-left column (software register)
spr_y  in  COORD_W  sprite top-left row
spr_sel  in  SEL_W  glyph index
spr_en  in  1  sprite enable
rom_addr  out  ADDR_WIDTH  address to glyph ROM (registered)
rom_q  in  DATA_WIDTH  ROM data, valid one cycle after rom_addr
out_rgb  out  DATA_WIDTH  composited pixel
out_valid  out  1  out_rgb valid
out_hit  out  1  opaque sprite pixel drawn

Behaviour:
- Reset (async assert, sync release): shadow regs, pipeline valids, rom_addr, out_rgb, out_valid and out_hit all 0. The sprite stays disabled until the first frame_start.
- Shadow regs: spr_x/spr_y/spr_sel/spr_en are captured on any clk edge with frame_start=1. Used from the next cycle. Mid-frame changes to the raw inputs are ignored, which prevents tearing.
- Stage 0 (cycle N, combinational):
  - dx = pix_x - sx, dy = pix_y - sy, both COORD_W+1 bits.
  - hit0 = spr_en_sh & pix_valid & pix_x>=sx & pix_y>=sy & dx<GLYPH_W & dy<GLYPH_H.
  - Address = {sel, dy[log2 H-1:0], dx[log2 W-1:0]}, zero-extended or truncated to ADDR_WIDTH.
- Stage 1 (edge N+1):
  - rom_addr is registered when hit0=1; otherwise it holds its previous value, which cuts ROM toggling.
  - v1, hit1 and bg1 are registered.
- Stage 2 (N+2): ROM presents rom_q. v2, hit2 and bg2 are registered.
- Stage 3 (N+3):
  - out_valid = v2.
  - out_hit = hit2 & (rom_q != KEY_RGB).
  - out_rgb = out_hit ? rom_q : (v2 ? bg2 : 0).
- Fixed latency is 3 cycles, fully pipelined, one pixel per clock, no stalls.
- Boundaries:
  - A sprite partly off the right or bottom edge is clipped naturally.
  - spr_x + GLYPH_W overflowing COORD_W must not wrap, which is why compares use the extended width.
  - frame_start together with pix_valid: the pixel uses the old shadow values.
  - pix_valid=0 bubbles propagate as out_valid=0 with out_rgb=0.

Optional Feature:
- GLYPH_MIRROR_EN defined: adds input port spr_flip (1 bit), shadowed at frame_start like the other sprite inputs. When the shadowed flip is 1, the column index becomes GLYPH_W-1-dx[log2 W-1:0], a horizontal mirror for left-facing karts.
- Undefined: no spr_flip port, and the column index is always dx.

Decomposition:
- Shared package glyph_pkg holds:
  - RGB_W = 24, KEY_RGB, GLYPH_W/GLYPH_H, and the glyph index constants GLYPH_KART = 0 and GLYPH_OBSTACLE = 1.
  - An rgb_t typedef.
- One natural sub-module, glyph_hit_calc: combinational stage-0 hit test and address generation. It is reusable when more sprite layers are added.

Test Plan:
- Reset then spr_x=100, spr_y=50, sel=0, en=1, frame_start; pix (100,50) valid -> rom_addr=0 at N+1; out_valid=1, out_hit=1, out_rgb=rom_q at N+3.
- Pix (131,81) -> rom_addr=1023. Pix (132,50) -> out_hit=0, out_rgb=bg_rgb, rom_addr unchanged.
- sel=1, pix (100,50) -> rom_addr=1024. ROM word 24'hFF00FF at that address -> out_hit=0, out_rgb=bg_rgb.
- spr_x=630, pix_x=639 -> hit (dx=9). spr_x=1020, pix_x=5 -> no hit (no wrap).
- Change spr_x mid-frame without frame_start -> rendering uses the old position; after frame_start -> the new position. Assert rst_n low mid-stream -> out_valid=0 immediately, no hits until the next frame_start.
- GLYPH_MIRROR_EN defined, flip=1, pix (100,50) -> rom_addr=31.
